// File: rtl/icache_pkg.sv
// Shared core package: widths, instruction-cache geometry defaults and the
// cache controller state type.
package icache_pkg;

   localparam int ADDR_WIDTH = 32;
   localparam int INST_WIDTH = 32;

   localparam int ICACHE_LINE_NUM   = 16;
   localparam int ICACHE_LINE_WORDS = 4;

   localparam int ICACHE_OFF_W = $clog2(ICACHE_LINE_WORDS);
   localparam int ICACHE_IDX_W = $clog2(ICACHE_LINE_NUM);
   localparam int ICACHE_TAG_W = ADDR_WIDTH - ICACHE_IDX_W - ICACHE_OFF_W - 2;

   typedef enum logic [2:0] {
      S_IDLE        = 3'd0,
      S_LOOKUP      = 3'd1,
      S_REFILL_REQ  = 3'd2,
      S_REFILL_WAIT = 3'd3,
      S_RESP        = 3'd4
   } icache_state_e;

   // Tag width for a given geometry; word addresses drop the two byte bits.
   function automatic int icache_tag_w(input int aw, input int line_num, input int line_words);
      return aw - $clog2(line_num) - $clog2(line_words) - 2;
   endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch-side and memory-side bundle of the instruction cache.
// slave  : the cache itself (answers fetches, issues memory reads).
// master : the environment (fetch unit plus instruction memory).
interface icache_if #(
   parameter int ADDR_WIDTH = icache_pkg::ADDR_WIDTH,
   parameter int INST_WIDTH = icache_pkg::INST_WIDTH
);

   logic                  req_valid_i;
   logic                  req_ready_o;
   logic [ADDR_WIDTH-1:0] req_addr_i;
   logic                  rsp_valid_o;
   logic [INST_WIDTH-1:0] rsp_instr_o;
   logic                  fence_i;
   logic                  mem_req_valid_o;
   logic                  mem_req_ready_i;
   logic [ADDR_WIDTH-1:0] mem_addr_o;
   logic                  mem_rsp_valid_i;
   logic [INST_WIDTH-1:0] mem_rsp_data_i;

   modport slave (
      input  req_valid_i, req_addr_i, fence_i,
      input  mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i,
      output req_ready_o, rsp_valid_o, rsp_instr_o,
      output mem_req_valid_o, mem_addr_o
   );

   modport master (
      output req_valid_i, req_addr_i, fence_i,
      output mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i,
      input  req_ready_o, rsp_valid_o, rsp_instr_o,
      input  mem_req_valid_o, mem_addr_o
   );

endinterface

// File: rtl/icache_data_array.sv
// Tag and data storage of the instruction cache. Flops without reset; line
// validity is tracked by the controller, so stale contents are never used.
module icache_data_array #(
   parameter int LINE_NUM   = 16,
   parameter int LINE_WORDS = 4,
   parameter int IDX_W      = 4,
   parameter int OFF_W      = 2,
   parameter int TAG_W      = 24,
   parameter int DATA_W     = 32
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [OFF_W-1:0]  wr_off,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              tag_wr_en,
   input  logic [TAG_W-1:0]  wr_tag,
   input  logic [IDX_W-1:0]  rd_idx,
   input  logic [OFF_W-1:0]  rd_off,
   output logic [TAG_W-1:0]  rd_tag,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] data_q [LINE_NUM][LINE_WORDS];
   logic [TAG_W-1:0]  tag_q  [LINE_NUM];

   // Refill write port: one word per memory response, tag with the last word.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         data_q[wr_idx][wr_off] <= wr_data;
      end
      if (tag_wr_en) begin
         tag_q[wr_idx] <= wr_tag;
      end
   end

   assign rd_tag  = tag_q[rd_idx];
   assign rd_data = data_q[rd_idx][rd_off];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with single-word line refill.
// Optional build macro ICACHE_PERF_CNT_EN adds hit/miss counters
// (hit_cnt_o, miss_cnt_o); without it those ports do not exist.
//
// state         | meaning
// --------------+------------------------------------------------------
// S_IDLE        | ready for a fetch, address latched on acceptance
// S_LOOKUP      | tag compare; hit answers this cycle, miss starts refill
// S_REFILL_REQ  | memory read of word cnt offered, held until ready
// S_REFILL_WAIT | waiting for the read data of word cnt
// S_RESP        | line complete, requested word returned
module icache #(
   parameter int ADDR_WIDTH = icache_pkg::ADDR_WIDTH,
   parameter int INST_WIDTH = icache_pkg::INST_WIDTH,
   parameter int LINE_NUM   = icache_pkg::ICACHE_LINE_NUM,
   parameter int LINE_WORDS = icache_pkg::ICACHE_LINE_WORDS
) (
   input  logic        clk,
   input  logic        rst_n,
`ifdef ICACHE_PERF_CNT_EN
   output logic [31:0] hit_cnt_o,
   output logic [31:0] miss_cnt_o,
`endif
   icache_if.slave     bus
);

   import icache_pkg::*;

   localparam int OFF_W = $clog2(LINE_WORDS);
   localparam int IDX_W = $clog2(LINE_NUM);
   localparam int TAG_W = icache_tag_w(ADDR_WIDTH, LINE_NUM, LINE_WORDS);
   localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);

   icache_state_e         state_q, state_d;
   logic [ADDR_WIDTH-1:2] addr_q;
   logic [OFF_W-1:0]      cnt_q, cnt_d;
   logic [LINE_NUM-1:0]   valid_q;
   logic                  flush_pending_q;

   logic [OFF_W-1:0]      req_off;
   logic [IDX_W-1:0]      req_idx;
   logic [TAG_W-1:0]      req_tag;
   logic [TAG_W-1:0]      rd_tag;
   logic [INST_WIDTH-1:0] rd_data;

   logic                  hit;
   logic                  accept;
   logic                  in_refill;
   logic                  refill_wr;
   logic                  refill_last;
   logic                  set_valid;

   logic                  ready_int;
   logic                  rsp_valid;
   logic [INST_WIDTH-1:0] rsp_instr;
   logic                  mem_req_valid;
   logic [ADDR_WIDTH-1:0] mem_addr;

   // Byte-select bits of the fetch address carry no information.
   logic                  unused_addr_lsb;
   assign unused_addr_lsb = ^bus.req_addr_i[1:0];

   assign req_off = addr_q[OFF_W+1:2];
   assign req_idx = addr_q[IDX_W+OFF_W+1:OFF_W+2];
   assign req_tag = addr_q[ADDR_WIDTH-1:IDX_W+OFF_W+2];

   // Lookup sees the valid bits before any same-cycle fence clears them.
   assign hit         = valid_q[req_idx] && (rd_tag == req_tag);
   assign accept      = (state_q == S_IDLE) && bus.req_valid_i;
   assign in_refill   = (state_q == S_REFILL_REQ) || (state_q == S_REFILL_WAIT);
   assign refill_wr   = (state_q == S_REFILL_WAIT) && bus.mem_rsp_valid_i;
   assign refill_last = refill_wr && (cnt_q == LAST_WORD);
   // A fence seen at any point of the refill keeps the new line invalid.
   assign set_valid   = refill_last && !flush_pending_q && !bus.fence_i;

   icache_data_array #(
      .LINE_NUM   (LINE_NUM),
      .LINE_WORDS (LINE_WORDS),
      .IDX_W      (IDX_W),
      .OFF_W      (OFF_W),
      .TAG_W      (TAG_W),
      .DATA_W     (INST_WIDTH)
   ) u_data_array (
      .clk       (clk),
      .wr_en     (refill_wr),
      .wr_idx    (req_idx),
      .wr_off    (cnt_q),
      .wr_data   (bus.mem_rsp_data_i),
      .tag_wr_en (refill_last),
      .wr_tag    (req_tag),
      .rd_idx    (req_idx),
      .rd_off    (req_off),
      .rd_tag    (rd_tag),
      .rd_data   (rd_data)
   );

   // FSM state and refill word counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state and all handshake outputs.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      ready_int     = 1'b0;
      rsp_valid     = 1'b0;
      rsp_instr     = '0;
      mem_req_valid = 1'b0;
      mem_addr      = '0;
      case (state_q)
         S_IDLE: begin
            ready_int = 1'b1;
            if (bus.req_valid_i) begin
               state_d = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            if (hit) begin
               rsp_valid = 1'b1;
               rsp_instr = rd_data;
               state_d   = S_IDLE;
            end else begin
               cnt_d   = '0;
               state_d = S_REFILL_REQ;
            end
         end
         S_REFILL_REQ: begin
            mem_req_valid = 1'b1;
            mem_addr      = {req_tag, req_idx, cnt_q, 2'b00};
            if (bus.mem_req_ready_i) begin
               state_d = S_REFILL_WAIT;
            end
         end
         S_REFILL_WAIT: begin
            if (bus.mem_rsp_valid_i) begin
               if (cnt_q == LAST_WORD) begin
                  state_d = S_RESP;
               end else begin
                  cnt_d   = cnt_q + 1'b1;
                  state_d = S_REFILL_REQ;
               end
            end
         end
         S_RESP: begin
            rsp_valid = 1'b1;
            rsp_instr = rd_data;
            state_d   = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Ready is forced low while reset is asserted even though the FSM sits in IDLE.
   assign bus.req_ready_o     = ready_int & rst_n;
   assign bus.rsp_valid_o     = rsp_valid;
   assign bus.rsp_instr_o     = rsp_instr;
   assign bus.mem_req_valid_o = mem_req_valid;
   assign bus.mem_addr_o      = mem_addr;

   // Fetch address capture on acceptance only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q <= '0;
      end else if (accept) begin
         addr_q <= bus.req_addr_i[ADDR_WIDTH-1:2];
      end
   end

   // Line valid bits: fence wipes everything, a clean refill sets one line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
      end else if (bus.fence_i) begin
         valid_q <= '0;
      end else if (set_valid) begin
         valid_q[req_idx] <= 1'b1;
      end
   end

   // Remembers a fence that arrived while a line was being refilled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flush_pending_q <= 1'b0;
      end else if (in_refill && bus.fence_i) begin
         flush_pending_q <= 1'b1;
      end else if ((state_q != S_IDLE) && (state_d == S_IDLE)) begin
         flush_pending_q <= 1'b0;
      end
   end

`ifdef ICACHE_PERF_CNT_EN
   // Hit/miss statistics, one count per lookup, free-running wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_cnt_o  <= '0;
         miss_cnt_o <= '0;
      end else if (state_q == S_LOOKUP) begin
         if (hit) begin
            hit_cnt_o <= hit_cnt_o + 32'd1;
         end else begin
            miss_cnt_o <= miss_cnt_o + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_icache.sv
// Directed plus randomized bench for icache, checked against a line-level
// cache model (valid/tag per index derived from address arithmetic).
module tb_icache;
   import icache_pkg::*;

   localparam int LINE_BYTES = ICACHE_LINE_WORDS * 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   icache_if #(.ADDR_WIDTH(ADDR_WIDTH), .INST_WIDTH(INST_WIDTH)) bus ();

`ifdef ICACHE_PERF_CNT_EN
   logic [31:0] hit_cnt;
   logic [31:0] miss_cnt;
`endif

   icache dut (
      .clk        (clk),
      .rst_n      (rst_n),
`ifdef ICACHE_PERF_CNT_EN
      .hit_cnt_o  (hit_cnt),
      .miss_cnt_o (miss_cnt),
`endif
      .bus        (bus.slave)
   );

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;
   int unsigned n_fail = 0;
   int unsigned n_memreq = 0;

   bit          m_valid [ICACHE_LINE_NUM];
   logic [31:0] m_tag   [ICACHE_LINE_NUM];
   int unsigned m_hits   = 0;
   int unsigned m_misses = 0;
   logic [31:0] salt;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ salt;
   endfunction

   task automatic check_bit(input string name, input logic obs, input logic exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", name, obs, exp);
      end
   endtask

   task automatic check_word(input string name, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", name, obs, exp);
      end
   endtask

   task automatic check_perf();
`ifdef ICACHE_PERF_CNT_EN
      check_word("hit_cnt", hit_cnt, m_hits);
      check_word("miss_cnt", miss_cnt, m_misses);
`endif
   endtask

   task automatic model_flush();
      for (int i = 0; i < ICACHE_LINE_NUM; i++) m_valid[i] = 1'b0;
   endtask

   task automatic fence_idle();
      bus.fence_i = 1'b1;
      model_flush();
      @(negedge clk);
      bus.fence_i = 1'b0;
   endtask

   // One fetch from the IDLE side to completion; optional backpressure,
   // fence during word fence_word, or reset once word abort_word is offered.
   task automatic do_fetch(input logic [31:0] addr, input int stall,
                           input int fence_word, input int abort_word);
      int          idx;
      logic [31:0] tg, line_base, exp_data, waddr;
      bit          hit, fenced;
      int          budget, wc;
      idx       = int'((addr / 32'(LINE_BYTES)) % 32'(ICACHE_LINE_NUM));
      tg        = addr / 32'(LINE_BYTES * ICACHE_LINE_NUM);
      line_base = addr - (addr % 32'(LINE_BYTES));
      exp_data  = mem_word(addr - (addr % 32'd4));
      hit       = m_valid[idx] && (m_tag[idx] == tg);
      fenced    = 1'b0;

      budget = 0;
      while (bus.req_ready_o !== 1'b1 && budget < 20) begin
         @(negedge clk);
         budget++;
      end
      check_bit("req_ready_idle", bus.req_ready_o, 1'b1);
      bus.req_valid_i = 1'b1;
      bus.req_addr_i  = addr;
      @(negedge clk);
      bus.req_valid_i = 1'b0;
      bus.req_addr_i  = $urandom;
      check_bit("req_ready_busy", bus.req_ready_o, 1'b0);
      check_bit("lookup_rsp_valid", bus.rsp_valid_o, hit);
      check_bit("lookup_no_mem", bus.mem_req_valid_o, 1'b0);
      if (hit) begin
         m_hits++;
         check_word("hit_data", bus.rsp_instr_o, exp_data);
         return;
      end
      m_misses++;

      for (int w = 0; w < ICACHE_LINE_WORDS; w++) begin
         waddr  = line_base + 32'(4 * w);
         budget = 0;
         while (bus.mem_req_valid_o !== 1'b1 && budget < 10) begin
            @(negedge clk);
            budget++;
         end
         check_bit("mem_req_valid", bus.mem_req_valid_o, 1'b1);
         check_word("mem_addr", bus.mem_addr_o, waddr);
         if (w == abort_word) begin
            rst_n = 1'b0;
            #1;
            check_bit("rst_mem_req_drop", bus.mem_req_valid_o, 1'b0);
            check_bit("rst_req_ready_low", bus.req_ready_o, 1'b0);
            model_flush();
            m_hits   = 0;
            m_misses = 0;
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            check_bit("post_rst_ready", bus.req_ready_o, 1'b1);
            bus.mem_rsp_valid_i = 1'b1;
            bus.mem_rsp_data_i  = $urandom;
            @(negedge clk);
            bus.mem_rsp_valid_i = 1'b0;
            check_bit("stray_rsp_ignored", bus.rsp_valid_o, 1'b0);
            check_bit("stray_no_mem_req", bus.mem_req_valid_o, 1'b0);
            return;
         end
         for (int s = 0; s < stall; s++) begin
            bus.req_valid_i     = 1'b1;
            bus.req_addr_i      = $urandom;
            bus.mem_rsp_valid_i = 1'($urandom_range(0, 1));
            bus.mem_rsp_data_i  = $urandom;
            @(negedge clk);
            check_bit("bp_valid_held", bus.mem_req_valid_o, 1'b1);
            check_word("bp_addr_held", bus.mem_addr_o, waddr);
         end
         bus.req_valid_i     = 1'b0;
         bus.mem_rsp_valid_i = 1'b0;
         bus.mem_req_ready_i = 1'b1;
         @(negedge clk);
         n_memreq++;
         bus.mem_req_ready_i = 1'b0;
         check_bit("mem_req_after_hs", bus.mem_req_valid_o, 1'b0);
         wc = $urandom_range(0, 2);
         if (w == fence_word && wc == 0) wc = 1;
         for (int c = 0; c < wc; c++) begin
            if (w == fence_word && c == 0) begin
               bus.fence_i = 1'b1;
               fenced      = 1'b1;
               model_flush();
            end
            @(negedge clk);
            bus.fence_i = 1'b0;
         end
         bus.mem_rsp_valid_i = 1'b1;
         bus.mem_rsp_data_i  = mem_word(waddr);
         @(negedge clk);
         bus.mem_rsp_valid_i = 1'b0;
         bus.mem_rsp_data_i  = $urandom;
      end
      check_bit("resp_valid", bus.rsp_valid_o, 1'b1);
      check_word("resp_data", bus.rsp_instr_o, exp_data);
      if (!fenced) begin
         m_valid[idx] = 1'b1;
         m_tag[idx]   = tg;
      end
      @(negedge clk);
      check_bit("resp_single_pulse", bus.rsp_valid_o, 1'b0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned base_req;
      logic [31:0] a;
      int          fw;

      salt = $urandom;
      model_flush();
      rst_n               = 1'b0;
      bus.req_valid_i     = 1'b0;
      bus.req_addr_i      = '0;
      bus.fence_i         = 1'b0;
      bus.mem_req_ready_i = 1'b0;
      bus.mem_rsp_valid_i = 1'b0;
      bus.mem_rsp_data_i  = '0;

      // reset values
      @(negedge clk);
      @(negedge clk);
      check_bit("rst_req_ready", bus.req_ready_o, 1'b0);
      check_bit("rst_rsp_valid", bus.rsp_valid_o, 1'b0);
      check_word("rst_rsp_instr", bus.rsp_instr_o, 32'h0);
      check_bit("rst_mem_req_valid", bus.mem_req_valid_o, 1'b0);
      check_word("rst_mem_addr", bus.mem_addr_o, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      check_bit("idle_ready", bus.req_ready_o, 1'b1);
      check_perf();

      // cold miss
      base_req = n_memreq;
      do_fetch(32'h8000_0004, 0, -1, -1);
      check_word("cold_miss_mem_reqs", n_memreq - base_req, 32'd4);
      check_perf();

      // hit after refill
      base_req = n_memreq;
      do_fetch(32'h8000_000C, 0, -1, -1);
      check_word("hit_mem_reqs", n_memreq - base_req, 32'd0);
      check_perf();

      // conflict on index 0
      base_req = n_memreq;
      do_fetch(32'h8000_0100, 0, -1, -1);
      do_fetch(32'h8000_0000, 0, -1, -1);
      check_word("conflict_mem_reqs", n_memreq - base_req, 32'd8);

      // memory backpressure
      do_fetch(32'h8000_0018, 5, -1, -1);
      do_fetch(32'h8000_0014, 0, -1, -1);

      // fence during refill, then fence while idle
      do_fetch(32'h8000_0024, 0, 1, -1);
      base_req = n_memreq;
      do_fetch(32'h8000_0024, 0, -1, -1);
      check_word("refetch_after_fence_mem_reqs", n_memreq - base_req, 32'd4);
      do_fetch(32'h8000_0020, 0, -1, -1);
      fence_idle();
      do_fetch(32'h8000_0020, 0, -1, -1);
      do_fetch(32'h8000_0000, 0, -1, -1);
      check_perf();

      // randomized traffic over a few tags and indices
      for (int n = 0; n < 40; n++) begin
         a = 32'h8000_0000 + (32'($urandom_range(0, 2)) << 8)
                           + (32'($urandom_range(0, 3)) << 4)
                           + (32'($urandom_range(0, 3)) << 2)
                           + 32'($urandom_range(0, 3));
         fw = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1;
         do_fetch(a, int'($urandom_range(0, 3)), fw, -1);
         if ($urandom_range(0, 7) == 0) fence_idle();
      end
      check_perf();

      // reset while the third refill word is being requested
      do_fetch(32'h8000_0304, 0, -1, 2);
      check_perf();
      base_req = n_memreq;
      do_fetch(32'h8000_0304, 0, -1, -1);
      check_word("post_rst_refill_mem_reqs", n_memreq - base_req, 32'd4);
      do_fetch(32'h8000_0300, 0, -1, -1);
      check_perf();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped, read-only instruction cache between the core's fetch unit and the instruction memory bus.
- Takes fetch addresses from the ifu and returns 32-bit instructions.
- On a miss, refills a whole line by issuing single-word reads on a valid/ready memory port.
- Serves the multi-cycle npc core; one outstanding fetch at a time.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- INST_WIDTH, 32, instruction/word width.
- LINE_NUM, 16, number of lines (power of 2).
- LINE_WORDS, 4, words per line (power of 2, >=2).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; asynchronous, active-low.
- req_valid_i  input  1  fetch request valid.
- req_ready_o  output  1  cache can accept a request.
- req_addr_i  input  ADDR_WIDTH  fetch byte address; bits [1:0] ignored.
- rsp_valid_o  output  1  one-cycle pulse: rsp_instr_o valid.
- rsp_instr_o  output  INST_WIDTH  fetched instruction.
- fence_i  input  1  invalidate all lines.
- mem_req_valid_o  output  1  memory read request valid.
- mem_req_ready_i  input  1  memory accepts request.
- mem_addr_o  output  ADDR_WIDTH  word-aligned memory read address.
- mem_rsp_valid_i  input  1  memory read data valid.
- mem_rsp_data_i  input  INST_WIDTH  memory read data.

Behaviour:
- Address split (defaults):
  - word offset [3:2] (log2 LINE_WORDS bits).
  - index [7:4] (log2 LINE_NUM bits).
  - tag [31:8].
- Storage: valid bit, tag and LINE_WORDS data words per line, all flops. Only valid bits are reset.
- Reset values: state IDLE, all valid=0, req_ready_o=0 during reset, rsp_valid_o=0, rsp_instr_o=0, mem_req_valid_o=0, mem_addr_o=0.
- FSM states: IDLE, LOOKUP, REFILL_REQ, REFILL_WAIT, RESP.
- IDLE:
  - req_ready_o=1.
  - A request is accepted on req_valid_i&&req_ready_o; the address is latched; next state is LOOKUP.
- LOOKUP (req_ready_o=0):
  - Hit = valid[idx] && tag[idx]==addr tag.
  - On hit: rsp_valid_o=1 this cycle, rsp_instr_o=data[idx][off], then IDLE.
  - Hit latency is one cycle after acceptance; throughput is one hit per 2 cycles.
  - On miss: word counter=0, go to REFILL_REQ.
- REFILL_REQ:
  - mem_req_valid_o=1, mem_addr_o={tag,idx,cnt,2'b00}.
  - Address is held stable until mem_req_ready_i; on handshake go to REFILL_WAIT.
- REFILL_WAIT:
  - mem_req_valid_o=0; wait for mem_rsp_valid_i.
  - On response, write data[idx][cnt].
  - If cnt==LINE_WORDS-1: write tag, set valid[idx] (unless flush pending), go to RESP.
  - Otherwise cnt+1, go to REFILL_REQ.
  - Exactly one memory transaction is outstanding; the line is always refilled word 0 upward.
- RESP: rsp_valid_o=1, rsp_instr_o=requested word, then IDLE.
- rsp_valid_o is a pulse with no backpressure; the consumer must sample it.
- fence_i:
  - In IDLE/LOOKUP/RESP: all valid bits clear next edge.
  - If fence_i and a LOOKUP are in the same cycle, the lookup uses pre-clear state.
  - During refill: sets flush_pending. The refill completes and the response is still delivered, but the valid bit is not set. flush_pending clears on entering IDLE.
- mem_rsp_valid_i outside REFILL_WAIT is ignored.
- Async reset mid-refill: FSM to IDLE, valids clear, mem_req_valid_o drops immediately. A late memory response is ignored.
- req_valid_i while not ready: no effect, the address is not latched.

Optional Feature:
- ICACHE_PERF_CNT_EN defined:
  - Adds outputs hit_cnt_o and miss_cnt_o, both 32 bits.
  - Each increments once per LOOKUP hit or miss respectively and wraps at 2^32.
  - Both reset to 0; fence_i does not clear them.
- Undefined: ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package (existing core package) holds:
  - ADDR_WIDTH and INST_WIDTH.
  - ICACHE_LINE_NUM and ICACHE_LINE_WORDS defaults.
  - Derived offset/index/tag widths.
  - FSM state enum typedef.
- One sub-module: icache_data_array (data + tag storage, with a write port for the refill word/tag and a combinational read of the tag and word at idx/off). Valid bits and the FSM stay in icache.

Test Plan:
- Cold miss: fetch 0x8000_0004 after reset.
  - Expect 4 memory requests 0x8000_0000, _0004, _0008, _000C, each answered.
  - Expect rsp_valid_o in RESP with the _0004 data.
  - Expect hit_cnt_o=0, miss_cnt_o=1.
- Hit after refill: fetch 0x8000_000C.
  - Expect rsp_valid_o exactly 1 cycle after acceptance with the refilled word.
  - Expect no memory request.
- Conflict: fetch 0x8000_0100 (same idx 0, tag differs), then 0x8000_0000.
  - Expect a refill each time (8 memory requests total).
- Backpressure: mem_req_ready_i low for 5 cycles during a refill.
  - Expect mem_req_valid_o and mem_addr_o held stable.
  - Expect a correct response after ready.
- Fence: fence_i pulsed during the 2nd refill word.
  - Expect the response still delivered.
  - Expect an immediate re-fetch of the same address to miss again.
  - Expect fence_i in IDLE to make all lines miss.
- Reset mid-refill: rst_n low after the 2nd word.
  - Expect mem_req_valid_o=0 immediately and req_ready_o=1 after release.
  - Expect a stray mem_rsp_valid_i to be ignored and the next fetch of the same line to miss.
